// File: rtl/ccff_loader_pkg.sv
// ----------------------------------------------------------------------------
// ccff_loader_pkg
// Shared definitions for the configuration-chain stream loader:
//   - loader_state_t : loader sequencing states (IDLE, LOAD, DONE)
//   - STALL_W        : width of the saturating stall counter
//   - CHAIN_LEN_*    : default configuration chain lengths per tile type
// ----------------------------------------------------------------------------
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

    localparam int STALL_W = 16;

    localparam int CHAIN_LEN_FLE = 1024;
    localparam int CHAIN_LEN_CLB = 4096;

endpackage

// File: rtl/ccff_piso.sv
// ----------------------------------------------------------------------------
// ccff_piso
// WORD_W-bit parallel-in / serial-out holding register. The MSB of the data
// register is the bit currently presented on the chain head, so the serial
// output comes straight from a flop.
// Ports:
//   i_clk, i_rst_n : clock and asynchronous active-low reset
//   i_flush        : discard any remaining bits (highest priority)
//   i_load         : capture i_word; its MSB is presented on the next cycle
//   i_word         : parallel word, bit WORD_W-1 leaves first
//   i_shift        : the presented bit is consumed on this edge
//   o_bit          : presented serial bit (holds after the last bit leaves)
//   o_valid        : a bit is being presented this cycle
//   o_last         : the presented bit is the final bit of the word
// ----------------------------------------------------------------------------
module ccff_piso #(
    parameter int WORD_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_word,
    input  logic              i_shift,
    output logic              o_bit,
    output logic              o_valid,
    output logic              o_last
);

    localparam int IDX_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] r_data;
    logic [IDX_W-1:0]  r_remain;
    logic              r_valid;

    // Holding register. A flush or the departure of the last bit only clears
    // the bookkeeping and leaves r_data alone, so the head output keeps its
    // previous value while nothing is presented. A load beats a shift so the
    // next word can replace the final bit on the same edge (gap-free stream).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data   <= '0;
            r_remain <= '0;
            r_valid  <= 1'b0;
        end else if (i_flush) begin
            r_remain <= '0;
            r_valid  <= 1'b0;
        end else if (i_load) begin
            r_data   <= i_word;
            r_remain <= IDX_W'(WORD_W);
            r_valid  <= 1'b1;
        end else if (i_shift && r_valid) begin
            if (r_remain == IDX_W'(1)) begin
                r_remain <= '0;
                r_valid  <= 1'b0;
            end else begin
                r_data   <= {r_data[WORD_W-2:0], 1'b0};
                r_remain <= r_remain - IDX_W'(1);
            end
        end
    end

    assign o_bit   = r_data[WORD_W-1];
    assign o_valid = r_valid;
    assign o_last  = r_valid && (r_remain == IDX_W'(1));

endmodule

// File: rtl/ccff_stream_loader.sv
// ----------------------------------------------------------------------------
// ccff_stream_loader
// Feeds the configuration chain of the logical tiles: accepts bitstream words
// on a valid/ready handshake, shifts them out MSB-first one bit per prog_clk,
// stops after exactly CHAIN_LEN bits and folds the bits returning from the
// chain tail into a parity signature of the displaced configuration.
// Ports:
//   i_prog_clk, i_prog_reset : clock, asynchronous active-low reset
//   i_start                  : begin a load (only honoured in IDLE)
//   i_word_in, i_word_valid  : bitstream word and its valid
//   o_word_ready             : word accepted on this cycle when valid
//   o_ccff_head              : serial bit to the chain head
//   o_ccff_shift_en          : chain clock-gate enable, high while a bit shows
//   i_ccff_tail              : serial bit returned from the chain tail
//   o_busy, o_done           : load in progress / end-of-load pulse
//   o_stall_cnt              : saturating count of starved LOAD cycles
//   o_tail_parity            : XOR of tail samples of the current/last load
// ----------------------------------------------------------------------------
module ccff_stream_loader
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = 11
) (
    input  logic               i_prog_clk,
    input  logic               i_prog_reset,
    input  logic               i_start,
    input  logic [WORD_W-1:0]  i_word_in,
    input  logic               i_word_valid,
    output logic               o_word_ready,
    output logic               o_ccff_head,
    output logic               o_ccff_shift_en,
    input  logic               i_ccff_tail,
    output logic               o_busy,
    output logic               o_done,
    output logic [STALL_W-1:0] o_stall_cnt,
    output logic               o_tail_parity
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);

    loader_state_t      r_state;
    loader_state_t      w_next_state;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [STALL_W-1:0] r_stall_cnt;
    logic               r_tail_parity;
    logic               r_entry;

    logic w_piso_bit;
    logic w_piso_valid;
    logic w_piso_last;
    logic w_shift;
    logic w_terminal;
    logic w_start;
    logic w_word_ready;
    logic w_handshake;
    logic w_flush;

    // The holding register only ever fills during LOAD and is flushed on the
    // final bit, so "a bit is presented" is simply its valid flag.
    assign w_shift     = w_piso_valid;
    assign w_terminal  = w_shift && (r_bit_cnt == LAST_IDX);
    assign w_start     = (r_state == IDLE) && i_start;
    assign w_handshake = i_word_valid && w_word_ready;
    assign w_flush     = w_start || w_terminal;

    ccff_piso #(
        .WORD_W (WORD_W)
    ) u_piso (
        .i_clk   (i_prog_clk),
        .i_rst_n (i_prog_reset),
        .i_flush (w_flush),
        .i_load  (w_handshake),
        .i_word  (i_word_in),
        .i_shift (w_shift),
        .o_bit   (w_piso_bit),
        .o_valid (w_piso_valid),
        .o_last  (w_piso_last)
    );

    // State register for the load sequencer.
    always_ff @(posedge i_prog_clk or negedge i_prog_reset) begin
        if (!i_prog_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and ready decode. Ready is offered when the holding register
    // is empty, or when its last bit leaves on this edge so the next word can
    // follow without a bubble; it is withheld on the final chain bit so no
    // word is taken once the chain is full.
    always_comb begin
        w_next_state = r_state;
        w_word_ready = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next_state = LOAD;
                end
            end
            LOAD: begin
                w_word_ready = !w_terminal &&
                               (!w_piso_valid || (w_piso_last && w_shift));
                if (w_terminal) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Bit counter, stall counter and tail parity. The first LOAD cycle can
    // never present a bit because the first word is only accepted there, so
    // it is pipeline fill rather than upstream starvation and is not counted
    // as a stall. Counter and parity hold after the load until the next start.
    always_ff @(posedge i_prog_clk or negedge i_prog_reset) begin
        if (!i_prog_reset) begin
            r_bit_cnt     <= '0;
            r_stall_cnt   <= '0;
            r_tail_parity <= 1'b0;
            r_entry       <= 1'b0;
        end else begin
            r_entry <= w_start;
            if (w_start) begin
                r_bit_cnt     <= '0;
                r_stall_cnt   <= '0;
                r_tail_parity <= 1'b0;
            end else if (r_state == LOAD) begin
                if (w_shift) begin
                    r_bit_cnt     <= r_bit_cnt + CNT_W'(1);
                    r_tail_parity <= r_tail_parity ^ i_ccff_tail;
                end else if (!r_entry && (r_stall_cnt != {STALL_W{1'b1}})) begin
                    r_stall_cnt <= r_stall_cnt + STALL_W'(1);
                end
            end
        end
    end

    assign o_word_ready    = w_word_ready;
    assign o_ccff_head     = w_piso_bit;
    assign o_ccff_shift_en = w_piso_valid;
    assign o_busy          = (r_state == LOAD);
    assign o_done          = (r_state == DONE);
    assign o_stall_cnt     = r_stall_cnt;
    assign o_tail_parity   = r_tail_parity;

endmodule
